inputs_sync_filter: RTL and testbench
=====================================

INPUTS_SYNC_FILTER -- requirements
Module: inputs_sync_filter

Interface
REQ-001 SHALL have parameter SIZE, default 1: number of independent input channels (1..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth per channel (2..4).
REQ-003 SHALL have parameter DEFAULT_OUT, width SIZE, default all 0: per-channel reset value (bit i for channel i).
REQ-004 SHALL have parameter FILTER_CNT, default 0: glitch-filter qualification length in cycles (0 = filter bypassed, max 65535).
REQ-005 SHALL have port iClk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port iRst  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port ivSync  input  SIZE: asynchronous raw inputs.
REQ-008 SHALL have port ovSync  output  SIZE: synchronized, filtered level per channel.
REQ-009 SHALL have port ovRise  output  SIZE: one-cycle pulse when ovSync[i] goes 0->1.
REQ-010 SHALL have port ovFall  output  SIZE: one-cycle pulse when ovSync[i] goes 1->0.

Function
REQ-011 Each channel SHALL pass ivSync[i] through a SYNC_STAGES-deep flop chain; last stage is the synced value s[i].
REQ-012 Channels SHALL be fully independent; no cross-channel logic or shared counters.
REQ-013 FILTER_CNT=0: ovSync[i] SHALL register s[i] every cycle (one extra flop).
REQ-014 FILTER_CNT>0: per-channel counter cnt, width ceil(log2(FILTER_CNT+1)), SHALL count cycles with s[i] != ovSync[i].
REQ-015 When s[i] != ovSync[i] and cnt == FILTER_CNT-1, ovSync[i] SHALL take s[i] and cnt SHALL clear to 0 on that edge.
REQ-016 When s[i] != ovSync[i] and cnt < FILTER_CNT-1, cnt SHALL increment; ovSync[i] unchanged.
REQ-017 When s[i] == ovSync[i], cnt SHALL clear to 0 (any glitch shorter than FILTER_CNT cycles is discarded).
REQ-018 Counter SHALL never exceed FILTER_CNT-1; no wrap-around.
REQ-019 Latency from input change to ovSync change (input stable, sampled at edge 0) SHALL be SYNC_STAGES + max(FILTER_CNT,1) cycles.
REQ-020 ovRise[i]/ovFall[i] SHALL be registered and asserted in the same cycle ovSync[i] changes, for exactly one cycle.
REQ-021 ovRise[i] and ovFall[i] SHALL never be asserted simultaneously.
REQ-022 Input toggling every cycle with FILTER_CNT>=2 SHALL produce no ovSync change and no edge pulses.

Reset
REQ-023 On iRst assertion, all sync stages and ovSync[i] SHALL asynchronously take DEFAULT_OUT[i].
REQ-024 On iRst assertion, all counters SHALL clear to 0 and ovRise/ovFall SHALL clear to 0.
REQ-025 Reset mid-qualification SHALL abort counting; no edge pulse SHALL be generated by reset or its release.
REQ-026 After iRst deassertion, an input differing from DEFAULT_OUT[i] SHALL be treated as a normal change (full latency per REQ-019, then one edge pulse).

Structure
REQ-027 Shared package inputs_sync_pkg SHALL hold SYNC_STAGES default/limits, FILTER_CNT limit and the counter-width function.
REQ-028 One sub-module sync_filter_bit (one channel: sync chain, counter, edge flops) SHALL be instantiated SIZE times via generate.
REQ-029 Sync chain flops SHALL carry the codebase's synchronizer attribute so timing tools treat them as CDC stages.

Verification
REQ-030 SIZE=4, DEFAULT_OUT=4'b1010, iRst high -> ovSync=4'b1010, ovRise=ovFall=0 immediately (before any clock edge).
REQ-031 SYNC_STAGES=2, FILTER_CNT=0, ivSync[0] 0->1 -> ovSync[0]=1 on 3rd edge, ovRise[0]=1 that cycle only.
REQ-032 SYNC_STAGES=3, FILTER_CNT=4, ivSync[1] 0->1 held -> ovSync[1]=1 on 7th edge, one ovRise[1] pulse.
REQ-033 FILTER_CNT=4, 3-cycle high glitch on ivSync[2] -> ovSync[2] stays 0, no ovRise/ovFall.
REQ-034 FILTER_CNT=4, iRst pulsed after 2 qualifying cycles -> ovSync=DEFAULT_OUT, counter 0, no edge pulse; re-qualification takes full 4 cycles.
REQ-035 SIZE=2, channel 0 rises while channel 1 falls same edge -> ovRise=2'b01, ovFall=2'b10 in the same cycle.

Source files
------------

// File: rtl/inputs_sync_pkg.sv
// Shared constants and helpers for the input synchronizer / glitch filter.
package inputs_sync_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int FILTER_CNT_MAX      = 65535;
  localparam int SIZE_MAX            = 64;

  // Width of the qualification counter: ceil(log2(filter_cnt+1)), never below 1.
  function automatic int cnt_width(input int filter_cnt);
    int w;
    w = $clog2(filter_cnt + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One channel: multi-flop synchronizer, optional glitch filter, edge pulses.
module sync_filter_bit
  import inputs_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic DEFAULT_VAL = 1'b0,
  parameter int   FILTER_CNT  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;
  logic synced;
  logic next_out;
  logic dout_q;
  logic rise_q;
  logic fall_q;

  // Synchronizer chain; the last stage is the metastability-safe sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{DEFAULT_VAL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CNT == 0) begin : g_bypass
      assign next_out = synced;
    end else begin : g_filter
      localparam int CW = cnt_width(FILTER_CNT);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // A change is accepted only after FILTER_CNT consecutive differing samples.
      always_comb begin
        cnt_d    = '0;
        next_out = dout_q;
        if (synced != dout_q) begin
          if (cnt_q == CNT_LAST) begin
            next_out = synced;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Qualification counter; reset aborts any qualification in progress.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Filtered level and edge pulses, all updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= DEFAULT_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      dout_q <= next_out;
      rise_q <= next_out & ~dout_q;
      fall_q <= ~next_out & dout_q;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/inputs_sync_filter.sv
// Bank of SIZE independent synchronizer/filter channels.
module inputs_sync_filter
  import inputs_sync_pkg::*;
#(
  parameter int              SIZE        = 1,
  parameter int              SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic [SIZE-1:0] DEFAULT_OUT = '0,
  parameter int              FILTER_CNT  = 0
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [SIZE-1:0] ivSync,
  output logic [SIZE-1:0] ovSync,
  output logic [SIZE-1:0] ovRise,
  output logic [SIZE-1:0] ovFall
);

  generate
    for (genvar i = 0; i < SIZE; i++) begin : g_ch
      sync_filter_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEFAULT_VAL (DEFAULT_OUT[i]),
        .FILTER_CNT  (FILTER_CNT)
      ) u_bit (
        .clk  (iClk),
        .rst  (iRst),
        .din  (ivSync[i]),
        .dout (ovSync[i]),
        .rise (ovRise[i]),
        .fall (ovFall[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_inputs_sync_filter.sv
// Bench for inputs_sync_filter: an unfiltered and a filtered instance
// checked every cycle against a window-based model, plus literal pins.
module tb_inputs_sync_filter;

  localparam logic [3:0] DFLT_A = 4'b1010;
  localparam logic [3:0] DFLT_B = 4'b0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] in_a = DFLT_A;
  logic [3:0] in_b = DFLT_B;
  logic [3:0] ovs_a, ovr_a, ovf_a;
  logic [3:0] ovs_b, ovr_b, ovf_b;

  inputs_sync_filter #(.SIZE(4), .SYNC_STAGES(2), .DEFAULT_OUT(DFLT_A), .FILTER_CNT(0)) dut_a (
    .iClk(clk), .iRst(rst_a), .ivSync(in_a),
    .ovSync(ovs_a), .ovRise(ovr_a), .ovFall(ovf_a)
  );

  inputs_sync_filter #(.SIZE(4), .SYNC_STAGES(3), .DEFAULT_OUT(DFLT_B), .FILTER_CNT(4)) dut_b (
    .iClk(clk), .iRst(rst_b), .ivSync(in_b),
    .ovSync(ovs_b), .ovRise(ovr_b), .ovFall(ovf_b)
  );

  // scoreboard counters
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the filter sees the input delayed by SYNC_STAGES samples; the
  // level flips once the last FILTER_CNT seen samples all disagree with it.
  int         sync_n [2] = '{2, 3};
  int         filt_n [2] = '{0, 4};
  logic [3:0] dflt   [2] = '{DFLT_A, DFLT_B};
  logic [3:0] in_hist[2][$];
  logic [3:0] s_hist [2][$];
  logic [3:0] m_sync [2] = '{DFLT_A, DFLT_B};
  logic [3:0] m_rise [2] = '{4'b0000, 4'b0000};
  logic [3:0] m_fall [2] = '{4'b0000, 4'b0000};

  task automatic model_step(input int d, input logic r, input logic [3:0] inv);
    logic [3:0] s;
    logic [3:0] nxt;
    int k;
    int idx;
    bit all_diff;
    if (r) begin
      in_hist[d].delete();
      s_hist[d].delete();
      m_sync[d] = dflt[d];
      m_rise[d] = 4'b0000;
      m_fall[d] = 4'b0000;
    end else begin
      in_hist[d].push_back(inv);
      k = in_hist[d].size();
      idx = k - 1 - sync_n[d];
      s = (idx >= 0) ? in_hist[d][idx] : dflt[d];
      s_hist[d].push_back(s);
      nxt = m_sync[d];
      for (int ch = 0; ch < 4; ch++) begin
        if (filt_n[d] == 0) begin
          nxt[ch] = s[ch];
        end else if (s_hist[d].size() >= filt_n[d]) begin
          all_diff = 1'b1;
          for (int j = 1; j <= filt_n[d]; j++)
            if (s_hist[d][s_hist[d].size() - j][ch] == m_sync[d][ch]) all_diff = 1'b0;
          if (all_diff) nxt[ch] = s[ch];
        end
      end
      m_rise[d] = nxt & ~m_sync[d];
      m_fall[d] = ~nxt & m_sync[d];
      m_sync[d] = nxt;
      while (in_hist[d].size() > 8) void'(in_hist[d].pop_front());
      while (s_hist[d].size() > 8) void'(s_hist[d].pop_front());
    end
  endtask

  always @(posedge clk or posedge rst_a) model_step(0, rst_a, in_a);
  always @(posedge clk or posedge rst_b) model_step(1, rst_b, in_b);

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    check("a_sync", ovs_a, m_sync[0]);
    check("a_rise", ovr_a, m_rise[0]);
    check("a_fall", ovf_a, m_fall[0]);
    check("b_sync", ovs_b, m_sync[1]);
    check("b_rise", ovr_b, m_rise[1]);
    check("b_fall", ovf_b, m_fall[1]);
  end

  // driver task
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    // reset values before any clock edge
    check("rst_a_sync", ovs_a, 4'b1010);
    check("rst_a_rise", ovr_a, 4'b0000);
    check("rst_a_fall", ovf_a, 4'b0000);
    check("rst_b_sync", ovs_b, 4'b0000);
    step(2);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(6);

    // unfiltered rise on channel 0: visible on the 3rd edge
    in_a = 4'b1011;
    step(2);
    check("a_lat_before", ovs_a, 4'b1010);
    step(1);
    check("a_lat_sync", ovs_a, 4'b1011);
    check("a_lat_rise", ovr_a, 4'b0001);
    check("a_lat_fall", ovf_a, 4'b0000);
    step(1);
    check("a_rise_once", ovr_a, 4'b0000);

    // simultaneous rise on ch0 and fall on ch1
    in_a = 4'b1010;
    step(5);
    in_a = 4'b1001;
    step(3);
    check("a_mix_sync", ovs_a, 4'b1001);
    check("a_mix_rise", ovr_a, 4'b0001);
    check("a_mix_fall", ovf_a, 4'b0010);

    // filtered rise on channel 1: visible on the 7th edge
    in_b = 4'b0010;
    step(6);
    check("b_lat_before", ovs_b, 4'b0000);
    step(1);
    check("b_lat_sync", ovs_b, 4'b0010);
    check("b_lat_rise", ovr_b, 4'b0010);
    step(1);
    check("b_rise_once", ovr_b, 4'b0000);

    // 3-cycle glitch on channel 2 is discarded
    in_b = 4'b0110;
    step(3);
    in_b = 4'b0010;
    step(10);
    check("b_glitch", ovs_b, 4'b0010);

    // channel 3 toggling every cycle never qualifies
    for (int i = 0; i < 20; i++) begin
      in_b[3] = ~in_b[3];
      step(1);
    end
    in_b[3] = 1'b0;
    step(10);
    check("b_toggle", ovs_b, 4'b0010);

    // reset in the middle of qualifying channel 0
    in_b = 4'b0011;
    step(5);
    rst_b = 1'b1;
    #1;
    check("b_midrst_sync", ovs_b, 4'b0000);
    check("b_midrst_rise", ovr_b, 4'b0000);
    check("b_midrst_fall", ovf_b, 4'b0000);
    step(1);
    rst_b = 1'b0;
    step(6);
    check("b_requal_before", ovs_b, 4'b0000);
    check("b_release_fall", ovf_b, 4'b0000);
    step(1);
    check("b_requal_sync", ovs_b, 4'b0011);
    check("b_requal_rise", ovr_b, 4'b0011);
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
